// File: rtl/ecc_pkg.sv
// ============================================================================
// Module : ecc_pkg
// Brief  : Shared widths, opcodes, FSM state encoding and the P-256 modulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ecc_pkg;

    localparam int ECC_WIDTH = 256;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [ECC_WIDTH-1:0] P256 =
        256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

endpackage

`default_nettype wire

// File: rtl/limb_addsub.sv
// ============================================================================
// Module : limb_addsub
// Brief  : Combinational single-limb adder/subtractor with carry/borrow chain.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module limb_addsub #(
    parameter int LIMB_W = 64
) (
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    input  logic              sub,
    output logic [LIMB_W-1:0] s,
    output logic              cout
);

    logic [LIMB_W:0] sum_w;
    logic [LIMB_W:0] diff_w;

    // In subtract mode cin/cout are borrows; the extended MSB of diff is the borrow-out.
    assign sum_w  = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
    assign diff_w = {1'b0, a} - {1'b0, b} - {{LIMB_W{1'b0}}, cin};

    assign s    = sub ? diff_w[LIMB_W-1:0] : sum_w[LIMB_W-1:0];
    assign cout = sub ? diff_w[LIMB_W]     : sum_w[LIMB_W];

endmodule

`default_nettype wire

// File: rtl/mod_addsub_serial.sv
// ============================================================================
// Module : mod_addsub_serial
// Brief  : Limb-serial modular add/subtract, (A+B) mod M or (A-B) mod M.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mod_addsub_serial
    import ecc_pkg::*;
#(
    parameter int WIDTH  = ECC_WIDTH,
    parameter int LIMB_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] opM,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int NLIMB = WIDTH / LIMB_W;
    localparam int IDXW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NLIMB - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_PH1  = PH1;
    localparam logic [1:0] ST_PH2  = PH2;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state_q,    state_d;
    logic [IDXW-1:0]  idx_q,      idx_d;
    logic             sub_q,      sub_d;
    logic             c_q,        c_d;
    logic             c1_q,       c1_d;
    logic [WIDTH-1:0] a_q,        a_d;
    logic [WIDTH-1:0] b_q,        b_d;
    logic [WIDTH-1:0] m_q,        m_d;
    logic [WIDTH-1:0] t_q,        t_d;
    logic [WIDTH-1:0] u_q,        u_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic [LIMB_W-1:0] la_a, la_b, la_s;
    logic              la_cin, la_sub, la_cout;
    logic              use_u;

    // Shift right by one limb, inserting a new limb at the top (LSB-first assembly).
    function automatic logic [WIDTH-1:0] shr_ins(input logic [WIDTH-1:0] x,
                                                 input logic [LIMB_W-1:0] l);
        return (x >> LIMB_W) | (WIDTH'(l) << (WIDTH - LIMB_W));
    endfunction

    limb_addsub #(
        .LIMB_W (LIMB_W)
    ) u_limb (
        .a    (la_a),
        .b    (la_b),
        .cin  (la_cin),
        .sub  (la_sub),
        .s    (la_s),
        .cout (la_cout)
    );

    // PH1 combines A,B with the requested op; PH2 applies the opposite op with M.
    always_comb begin
        la_a   = a_q[LIMB_W-1:0];
        la_b   = b_q[LIMB_W-1:0];
        la_sub = sub_q;
        la_cin = c_q;
        if (state_q == ST_PH2) begin
            la_a   = t_q[LIMB_W-1:0];
            la_b   = m_q[LIMB_W-1:0];
            la_sub = ~sub_q;
        end
    end

    assign use_u = sub_q ? c1_q : (c1_q | ~la_cout);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sub_d      = sub_q;
        c_d        = c_q;
        c1_d       = c1_q;
        a_d        = a_q;
        b_d        = b_q;
        m_d        = m_q;
        t_d        = t_q;
        u_d        = u_q;
        out_data_d = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = opA;
                    b_d     = opB;
                    m_d     = opM;
                    sub_d   = op_sub;
                    idx_d   = '0;
                    c_d     = 1'b0;
                    state_d = ST_PH1;
                end
            end
            ST_PH1: begin
                t_d   = shr_ins(t_q, la_s);
                a_d   = a_q >> LIMB_W;
                b_d   = b_q >> LIMB_W;
                c_d   = la_cout;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    c1_d    = la_cout;
                    c_d     = 1'b0;
                    idx_d   = '0;
                    state_d = ST_PH2;
                end
            end
            ST_PH2: begin
                // T and M rotate so T is whole again when the pass completes.
                t_d   = shr_ins(t_q, t_q[LIMB_W-1:0]);
                m_d   = shr_ins(m_q, m_q[LIMB_W-1:0]);
                u_d   = shr_ins(u_q, la_s);
                c_d   = la_cout;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    idx_d      = '0;
                    out_data_d = use_u ? u_d : t_d;
                    state_d    = ST_DONE;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            sub_q      <= 1'b0;
            c_q        <= 1'b0;
            c1_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            m_q        <= '0;
            t_q        <= '0;
            u_q        <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sub_q      <= sub_d;
            c_q        <= c_d;
            c1_q       <= c1_d;
            a_q        <= a_d;
            b_q        <= b_d;
            m_q        <= m_d;
            t_q        <= t_d;
            u_q        <= u_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_addsub_serial.sv
// ============================================================================
// Module : tb_mod_addsub_serial
// Brief  : Scoreboard bench for mod_addsub_serial (directed plus random vectors).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mod_addsub_serial;
    import ecc_pkg::*;

    localparam int W = 256;
    localparam logic [W-1:0] P = P256;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op_sub = 1'b0;
    logic [W-1:0] opA = '0, opB = '0, opM = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    logic         prev_valid = 1'b0;

    mod_addsub_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .opA       (opA),
        .opB       (opB),
        .opM       (opM),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic logic [W-1:0] ref_model(input bit sub, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [W-1:0] m);
        logic [W:0] s;
        if (!sub) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, m}) s = s - {1'b0, m};
        end else if (a >= b) begin
            s = {1'b0, a} - {1'b0, b};
        end else begin
            s = {1'b0, a} + {1'b0, m} - {1'b0, b};
        end
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_below(input logic [W-1:0] m);
        logic [W-1:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[W-33:0], 32'($urandom())};
        if (r >= m) r = r - m;
        return r;
    endfunction

    // Monitor: latency of each accepted bundle and scoreboard pop on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) acc_q.push_back(cyc + 1);
            if (out_valid && !prev_valid) begin
                if (acc_q.size() == 0) chk("latency_no_accept", 256'(1), 256'(0));
                else chk("latency", 256'(cyc - acc_q.pop_front()), 256'(8));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", out_data, '1);
                else chk("out_data", out_data, exp_q.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    task automatic issue(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] m, input logic [W-1:0] exp);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("in_ready_timeout", 256'(in_ready), 256'(1));
        in_valid = 1'b1;
        op_sub   = sub;
        opA = a; opB = b; opM = m;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_sub   = ~sub;
        opA = '1; opB = '1; opM = 256'd7;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_empty", 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int n;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(OP_SUB, 256'd5, 256'd3, P, 256'd2);
        issue(OP_SUB, 256'd3, 256'd5, P, P - 256'd2);
        issue(OP_ADD, P - 256'd1, 256'd1, P, 256'd0);
        issue(OP_ADD, P - 256'd1, P - 256'd1, P, P - 256'd2);
        issue(OP_ADD, 256'd1, 256'd2, P, 256'd3);
        issue(OP_ADD, 256'd7, 256'd9, 256'd13, 256'd3);
        issue(OP_SUB, 256'd2, 256'd9, 256'd13, 256'd6);
        drain();

        // Backpressure with a competing bundle held valid.
        out_ready = 1'b0;
        issue(OP_ADD, 256'd1, 256'd2, P, 256'd3);
        in_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 256'(out_valid), 256'(1));
            chk("bp_out_data", out_data, 256'd3);
            chk("bp_in_ready", 256'(in_ready), 256'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_release_in_ready", 256'(in_ready), 256'(1));
        chk("bp_release_out_valid", 256'(out_valid), 256'(0));
        chk("bp_no_second_accept", 256'(acc_q.size()), 256'(0));

        // Reset in the middle of the PH2 pass.
        issue(OP_ADD, 256'd4, 256'd5, P, 256'd9);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 256'(out_valid), 256'(0));
        chk("midrst_out_data", out_data, '0);
        chk("midrst_in_ready", 256'(in_ready), 256'(1));
        issue(OP_SUB, 256'd0, 256'd1, P, P - 256'd1);
        drain();

        for (int i = 0; i < 8; i++) begin
            ra = rand_below(P);
            rb = rand_below(P);
            issue(i[0], ra, rb, P, ref_model(i[0], ra, rb, P));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
